// File: rtl/common.sv
// Shared machine-word and data-bus types used across the pipeline.
package common;

    localparam int unsigned WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        logic [2:0] size;
        logic [7:0] strobe;
        word_t      data;
    } dbus_req_t;

    typedef struct packed {
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage types: memory-op descriptor, access-size encoding and memory-stage FSM states.
package pipes;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef struct packed {
        logic   read;
        logic   write;
        msize_t size;
        logic   is_unsigned;
    } memop_t;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_ISSUE = 2'd1,
        MEM_DONE  = 2'd2
    } mem_state_t;

    // An access is aligned when the low address bits below its size are all zero.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input msize_t size);
        logic mis;
        case (size)
            MSIZE_B: mis = 1'b0;
            MSIZE_H: mis = addr_lo[0];
            MSIZE_W: mis = |addr_lo[1:0];
            MSIZE_D: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-to-memory, data-bus and memory-to-writeback signals of the memory stage.
interface mem_access_if;
    import common::*;
    import pipes::*;

    logic       in_valid;
    logic       in_ready;
    word_t      in_addr;
    word_t      in_wdata;
    memop_t     in_memop;
    logic [4:0] in_rd;
    logic       in_wen;

    logic       dreq_valid;
    word_t      dreq_addr;
    logic [2:0] dreq_size;
    logic [7:0] dreq_strobe;
    word_t      dreq_data;
    logic       dresp_data_ok;
    word_t      dresp_data;

    logic       out_valid;
    logic [4:0] out_rd;
    logic       out_wen;
    word_t      out_data;
    logic       out_misalign;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_memop, in_rd, in_wen,
        input  dresp_data_ok, dresp_data,
        output in_ready,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output out_valid, out_rd, out_wen, out_data, out_misalign
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_memop, in_rd, in_wen,
        output dresp_data_ok, dresp_data,
        input  in_ready,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  out_valid, out_rd, out_wen, out_data, out_misalign
    );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: store data shift and strobe, load extract and sign/zero extension.
module mem_align
    import common::*;
    import pipes::*;
(
    input  logic [2:0] st_off,
    input  msize_t     st_size,
    input  word_t      st_wdata,
    output logic [7:0] st_strobe,
    output word_t      st_data,
    input  logic [2:0] ld_off,
    input  msize_t     ld_size,
    input  logic       ld_unsigned,
    input  word_t      ld_rdata,
    output word_t      ld_data
);

    logic [7:0] size_mask_s;
    word_t      ld_shift_s;

    // Store lanes: move the low-aligned data and its byte mask up to the addressed lane.
    always_comb begin
        st_data = st_wdata << {st_off, 3'b000};
        case (st_size)
            MSIZE_B: size_mask_s = 8'h01;
            MSIZE_H: size_mask_s = 8'h03;
            MSIZE_W: size_mask_s = 8'h0F;
            MSIZE_D: size_mask_s = 8'hFF;
            default: size_mask_s = 8'h00;
        endcase
        st_strobe = size_mask_s << st_off;
    end

    // Load lanes: bring the addressed bytes down to bit 0, then extend to a full word.
    always_comb begin
        ld_shift_s = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            MSIZE_B: ld_data = ld_unsigned ? {56'd0, ld_shift_s[7:0]}
                                           : {{56{ld_shift_s[7]}}, ld_shift_s[7:0]};
            MSIZE_H: ld_data = ld_unsigned ? {48'd0, ld_shift_s[15:0]}
                                           : {{48{ld_shift_s[15]}}, ld_shift_s[15:0]};
            MSIZE_W: ld_data = ld_unsigned ? {32'd0, ld_shift_s[31:0]}
                                           : {{32{ld_shift_s[31]}}, ld_shift_s[31:0]};
            MSIZE_D: ld_data = ld_rdata;
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues one data-bus access per load/store and hands results to writeback.
module mem_access
    import common::*;
    import pipes::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);

    mem_state_t state_q, state_d;
    word_t      addr_q, addr_d;
    word_t      data_q, data_d;
    word_t      sdata_q, sdata_d;
    logic [7:0] strobe_q, strobe_d;
    msize_t     size_q, size_d;
    logic       uns_q, uns_d;
    logic       read_q, read_d;
    logic [4:0] rd_q, rd_d;
    logic       wen_q, wen_d;
    logic       misalign_q, misalign_d;

    logic       in_ready_s;
    logic       accept_s;
    logic       mem_op_s;
    logic       mis_s;
    logic [7:0] st_strobe_s;
    word_t      st_data_s;
    word_t      ld_data_s;
    dbus_req_t  dreq_s;
    dbus_resp_t dresp_s;

    assign dresp_s    = '{data_ok: bus.dresp_data_ok, data: bus.dresp_data};
    assign in_ready_s = (state_q != MEM_ISSUE);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign mem_op_s   = bus.in_memop.read || bus.in_memop.write;
    assign mis_s      = mem_op_s && is_misaligned(bus.in_addr[2:0], bus.in_memop.size);

    mem_align u_align (
        .st_off      (bus.in_addr[2:0]),
        .st_size     (bus.in_memop.size),
        .st_wdata    (bus.in_wdata),
        .st_strobe   (st_strobe_s),
        .st_data     (st_data_s),
        .ld_off      (addr_q[2:0]),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_rdata    (dresp_s.data),
        .ld_data     (ld_data_s)
    );

    // Next-state and latch logic; store lanes are precomputed at accept so the bus sees flops.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sdata_d    = sdata_q;
        strobe_d   = strobe_q;
        size_d     = size_q;
        uns_d      = uns_q;
        read_d     = read_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        misalign_d = misalign_q;
        case (state_q)
            MEM_IDLE, MEM_DONE: begin
                if (accept_s) begin
                    addr_d     = bus.in_addr;
                    data_d     = bus.in_addr;
                    sdata_d    = bus.in_memop.write ? st_data_s : 64'd0;
                    strobe_d   = bus.in_memop.write ? st_strobe_s : 8'h00;
                    size_d     = bus.in_memop.size;
                    uns_d      = bus.in_memop.is_unsigned;
                    read_d     = bus.in_memop.read;
                    rd_d       = bus.in_rd;
                    wen_d      = bus.in_wen && !bus.in_memop.write && !mis_s;
                    misalign_d = mis_s;
                    state_d    = (mem_op_s && !mis_s) ? MEM_ISSUE : MEM_DONE;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_ISSUE: begin
                if (dresp_s.data_ok) begin
                    state_d = MEM_DONE;
                    if (read_q) begin
                        data_d = ld_data_s;
                    end else begin
                        data_d = data_q;
                    end
                end else begin
                    state_d = MEM_ISSUE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Stage registers with synchronous reset; an outstanding request is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MEM_IDLE;
            addr_q     <= 64'd0;
            data_q     <= 64'd0;
            sdata_q    <= 64'd0;
            strobe_q   <= 8'h00;
            size_q     <= MSIZE_B;
            uns_q      <= 1'b0;
            read_q     <= 1'b0;
            rd_q       <= 5'd0;
            wen_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sdata_q    <= sdata_d;
            strobe_q   <= strobe_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            read_q     <= read_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            misalign_q <= misalign_d;
        end
    end

    assign dreq_s = '{valid:  (state_q == MEM_ISSUE),
                      addr:   addr_q,
                      size:   {1'b0, size_q},
                      strobe: strobe_q,
                      data:   sdata_q};

    assign bus.in_ready     = in_ready_s;
    assign bus.dreq_valid   = dreq_s.valid;
    assign bus.dreq_addr    = dreq_s.addr;
    assign bus.dreq_size    = dreq_s.size;
    assign bus.dreq_strobe  = dreq_s.strobe;
    assign bus.dreq_data    = dreq_s.data;
    assign bus.out_valid    = (state_q == MEM_DONE);
    assign bus.out_rd       = rd_q;
    assign bus.out_wen      = wen_q;
    assign bus.out_data     = data_q;
    assign bus.out_misalign = misalign_q;

endmodule
